avalon_bin2bcd_master: RTL and testbench

AVALON_BIN2BCD_MASTER -- requirements
Module: avalon_bin2bcd_master

---
 rtl/avalon_bin2bcd_master.sv | 146 ++++++++++++++
 tb/tb_avalon_bin2bcd_master.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/avalon_bin2bcd_master.sv
// avalon_bin2bcd_master
// Takes a 27-bit unsigned binary value and converts it to 8-digit packed BCD
// using a sequential double-dabble (one iteration per clock). The result is
// written to a 7-segment display peripheral over Avalon-MM.
// Values above 99,999,999 skip conversion and write 0xEEEEEEEE with ovf set.
module avalon_bin2bcd_master #(
  parameter int unsigned DISP_ADDR = 32'd0,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [26:0]       bin_data,
  input  logic              bin_valid,
  output logic              bin_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic              ovf,
  output logic              wr_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [26:0] MAX_DISP  = 27'd99_999_999;
  localparam logic [31:0] OVF_CODE  = 32'hEEEE_EEEE;
  localparam logic [4:0]  LAST_ITER = 5'd26;

  state_t      state_r;
  state_t      state_s;
  logic [58:0] shift_r;
  logic [58:0] step_s;
  logic [4:0]  iter_r;
  logic [31:0] wdata_r;
  logic        ovf_r;
  logic        in_range_s;

  // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
  function automatic logic [58:0] dd_step(input logic [58:0] sr);
    logic [58:0] adj;
    adj = sr;
    for (int i = 0; i < 8; i++) begin
      if (adj[27 + 4*i +: 4] >= 4'd5) begin
        adj[27 + 4*i +: 4] = adj[27 + 4*i +: 4] + 4'd3;
      end else begin
        adj[27 + 4*i +: 4] = adj[27 + 4*i +: 4];
      end
    end
    return adj << 1;
  endfunction

  assign step_s     = dd_step(shift_r);
  assign in_range_s = (bin_data <= MAX_DISP);

  // Handshake and bus outputs decode straight from registered state; reset masks them.
  assign bin_ready      = (state_r == IDLE)  && !reset;
  assign avm_write      = (state_r == WRITE) && !reset;
  assign wr_done        = (state_r == DONE)  && !reset;
  assign avm_address    = ADDR_W'(DISP_ADDR);
  assign avm_writedata  = wdata_r;
  assign avm_byteenable = 4'b1111;
  assign ovf            = ovf_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bin_valid) begin
          if (in_range_s) begin
            state_s = CONVERT;
          end else begin
            state_s = WRITE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CONVERT: begin
        if (iter_r == LAST_ITER) begin
          state_s = WRITE;
        end else begin
          state_s = CONVERT;
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          state_s = DONE;
        end else begin
          state_s = WRITE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate during CONVERT, latch the result for the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r <= 59'd0;
      iter_r  <= 5'd0;
      wdata_r <= 32'd0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bin_valid) begin
            shift_r <= {32'd0, bin_data};
            iter_r  <= 5'd0;
            ovf_r   <= !in_range_s;
            if (!in_range_s) begin
              wdata_r <= OVF_CODE;
            end
          end
        end
        CONVERT: begin
          shift_r <= step_s;
          iter_r  <= iter_r + 5'd1;
          if (iter_r == LAST_ITER) begin
            wdata_r <= step_s[58:27];
          end
        end
        default: begin
          shift_r <= shift_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_bin2bcd_master.sv
// Table-driven bench for avalon_bin2bcd_master with a write-data scoreboard.
module tb_avalon_bin2bcd_master;

  localparam int unsigned DADDR = 32'h0000_1040;

  logic        clk = 1'b0;
  logic        reset;
  logic [26:0] bin_data;
  logic        bin_valid;
  logic        bin_ready;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic        ovf;
  logic        wr_done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [26:0] bin;
    int          stall;
    logic [31:0] exp_d;
    logic        exp_o;
    int          exp_wc;
  } vec_t;

  vec_t tbl[8];

  avalon_bin2bcd_master #(.DISP_ADDR(DADDR), .ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .bin_data       (bin_data),
    .bin_valid      (bin_valid),
    .bin_ready      (bin_ready),
    .avm_address    (avm_address),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_byteenable (avm_byteenable),
    .avm_waitrequest(avm_waitrequest),
    .ovf            (ovf),
    .wr_done        (wr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one value, play the slave with 'stall' waitrequest cycles, and check timing/data.
  // Optionally pulse bin_valid with inj_v at cycle inj_cyc to prove it is ignored.
  task automatic xfer(input logic [26:0] v, input int stall, input logic [31:0] ed,
                      input logic eo, input int ewc, input int inj_cyc, input logic [26:0] inj_v);
    int cyc, first_w, nw, nd, acc_cyc;
    bit done;
    logic [31:0] got;
    @(negedge clk);
    chk("ready_before_accept", {31'd0, bin_ready}, 32'd1);
    bin_valid = 1'b1;
    bin_data  = v;
    sb.push_back(ed);
    @(posedge clk);
    #1;
    bin_valid = 1'b0;
    bin_data  = 27'h5A5A5A5;
    cyc = 1; first_w = -1; nw = 0; nd = 0; acc_cyc = -1; done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (cyc == inj_cyc) begin
        bin_valid = 1'b1;
        bin_data  = inj_v;
      end else begin
        bin_valid = 1'b0;
      end
      if (cyc == 1) chk("busy_ready", {31'd0, bin_ready}, 32'd0);
      if (avm_write) begin
        if (first_w < 0) begin
          first_w = cyc;
          chk("first_write_cycle", first_w, ewc);
          chk("ovf_at_write", {31'd0, ovf}, {31'd0, eo});
        end
        nw++;
        avm_waitrequest = (nw <= stall);
        chk("write_address", avm_address, DADDR);
        chk("byteenable", {28'd0, avm_byteenable}, 32'hF);
        if (sb.size() > 0) chk("write_data_hold", avm_writedata, sb[0]);
        else chk("scoreboard_nonempty", 32'd0, 32'd1);
        if (!avm_waitrequest) begin
          acc_cyc = cyc;
          if (sb.size() > 0) begin
            got = sb.pop_front();
            chk("write_data", avm_writedata, got);
          end
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
      if (wr_done) begin
        nd++;
        chk("wr_done_cycle", cyc, acc_cyc + 1);
      end
      if (acc_cyc >= 0 && cyc == acc_cyc + 1) chk("write_drop", {31'd0, avm_write}, 32'd0);
      if (acc_cyc >= 0 && cyc == acc_cyc + 2) begin
        chk("ready_after", {31'd0, bin_ready}, 32'd1);
        chk("ovf_stable", {31'd0, ovf}, {31'd0, eo});
        done = 1'b1;
      end
      if (!done) begin
        @(posedge clk);
        cyc++;
      end
    end
    bin_valid = 1'b0;
    chk("xfer_completed", {31'd0, done}, 32'd1);
    chk("write_cycles", nw, stall + 1);
    chk("wr_done_count", nd, 1);
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    int nw, nd;
    tbl[0] = '{27'd12_345_678,  0, 32'h1234_5678, 1'b0, 28};
    tbl[1] = '{27'd0,           0, 32'h0000_0000, 1'b0, 28};
    tbl[2] = '{27'd99_999_999,  0, 32'h9999_9999, 1'b0, 28};
    tbl[3] = '{27'd100_000_000, 0, 32'hEEEE_EEEE, 1'b1, 1};
    tbl[4] = '{27'd5,           0, 32'h0000_0005, 1'b0, 28};
    tbl[5] = '{27'd134_217_727, 2, 32'hEEEE_EEEE, 1'b1, 1};
    tbl[6] = '{27'd87_654_321,  5, 32'h8765_4321, 1'b0, 28};
    tbl[7] = '{27'd10,          1, 32'h0000_0010, 1'b0, 28};

    reset = 1'b1;
    bin_valid = 1'b0;
    bin_data = 27'd0;
    avm_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_write", {31'd0, avm_write}, 32'd0);
    chk("rst_data", avm_writedata, 32'd0);
    chk("rst_addr", avm_address, DADDR);
    chk("rst_be", {28'd0, avm_byteenable}, 32'hF);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_done", {31'd0, wr_done}, 32'd0);
    chk("rst_ready", {31'd0, bin_ready}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, bin_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      xfer(tbl[i].bin, tbl[i].stall, tbl[i].exp_d, tbl[i].exp_o, tbl[i].exp_wc, -1, 27'd0);
    end

    // A value offered mid-conversion must be dropped.
    xfer(27'd42, 0, 32'h0000_0042, 1'b0, 28, 5, 27'd7);
    nw = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (avm_write) nw++;
    end
    chk("no_write_of_ignored", nw, 0);

    // Reset in the 10th CONVERT cycle aborts everything.
    @(negedge clk);
    bin_valid = 1'b1;
    bin_data  = 27'd12_345_678;
    @(posedge clk);
    #1 bin_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_write", {31'd0, avm_write}, 32'd0);
    chk("abort_done", {31'd0, wr_done}, 32'd0);
    chk("abort_ready", {31'd0, bin_ready}, 32'd0);
    chk("abort_data", avm_writedata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_release", {31'd0, bin_ready}, 32'd1);
    nw = 0; nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (avm_write) nw++;
      if (wr_done) nd++;
    end
    chk("abort_no_write", nw, 0);
    chk("abort_no_done", nd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
